vx_ag_tcu_step_seq: RTL and testbench
=====================================

// Module: VX_ag_tcu_step_seq
// PURPOSE
//  Issue-side sequencer for the AG-TCU FP unit; drives the unit's execute handshake.
//  - Accepts one tile macro-op (M x N sub-block steps).
//  - Expands it into per-step micro-ops carrying step_m/step_n and a per-step rd.
//  - Limits in-flight micro-ops with a credit counter sized to the unit's metadata queue depth.
//  - Raises done after the last result retires.
// PARAMETERS
//  UUID_W      44  uuid width
//  NW_W        2   warp-id width
//  PC_W        30  PC width
//  RD_W        6   destination register index width
//  STEP_W      4   step index width; step-count fields encode count-1, so 1..2^STEP_W steps
//  MAX_INFL    16  max micro-ops issued but not yet retired; power of two, >=2
// PORTS
//  clk         in   1       clock
//  reset       in   1       asynchronous, active-high reset
//  in_valid    in   1       macro-op valid
//  in_ready    out  1       macro-op accepted when in_valid && in_ready
//  in_uuid     in   UUID_W  macro-op uuid
//  in_wid      in   NW_W    warp id
//  in_pc       in   PC_W    PC
//  in_rd       in   RD_W    base destination register
//  in_fmt_s    in   4       source format
//  in_fmt_d    in   4       destination format
//  in_m_cnt    in   STEP_W  M steps minus 1
//  in_n_cnt    in   STEP_W  N steps minus 1
//  out_valid   out  1       micro-op valid toward TCU execute port
//  out_ready   in   1       TCU ready
//  out_uuid    out  UUID_W  latched in_uuid
//  out_wid     out  NW_W    latched in_wid
//  out_pc      out  PC_W    latched in_pc
//  out_fmt_s   out  4       latched in_fmt_s
//  out_fmt_d   out  4       latched in_fmt_d
//  out_rd      out  RD_W    in_rd + m*(n_cnt+1) + n, modulo 2^RD_W
//  out_step_m  out  STEP_W  current m
//  out_step_n  out  STEP_W  current n
//  out_sop     out  1       first micro-op of the macro-op
//  out_eop     out  1       last micro-op of the macro-op
//  rsp_fire    in   1       one TCU result accepted downstream this cycle
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle pulse when the macro-op fully retires
// BEHAVIOUR
//  - Reset (async assert, sync deassert): state=IDLE, m=n=0, credits=0.
//    All out_* and done are 0, in_ready=1, busy=0. Reset mid-operation abandons the macro-op silently.
//  - FSM states:
//    IDLE:  in_ready=1. On in fire, latch all fields, m=n=0, go to ISSUE.
//    ISSUE: out_valid = (credits != MAX_INFL); fields are driven from registers only.
//      Each out fire:
//        n==n_cnt: n=0, m++
//        else:     n++
//      When the fire has m==m_cnt && n==n_cnt, go to DRAIN.
//    DRAIN: wait for credits==0. In the cycle credits would reach 0, pulse done (registered, next cycle) and go to IDLE.
//  - Issue order: n fastest, then m. out_sop = (m==0 && n==0); out_eop = (m==m_cnt && n==n_cnt).
//  - Handshake: once out_valid=1, payload is held stable until out_ready. out_valid never drops except on credit exhaustion.
//    Credit exhaustion may only block assertion, because the counter cannot rise while valid is pending.
//  - Credits, width clog2(MAX_INFL)+1:
//    out fire alone: +1. rsp_fire alone: -1. Both in the same cycle: unchanged.
//    rsp_fire with credits==0 is a protocol error: assertion fires, counter holds at 0.
//  - Throughput: 1 micro-op/cycle with out_ready=1 and credits available.
//    First out_valid appears the cycle after in fire. No in_ready until done.
//  - Single-step macro-op (m_cnt=n_cnt=0): one micro-op with sop=eop=1.
//  - rsp_fire in IDLE is an error as above.
// STRUCTURE
//  - VX_ag_tcu_pkg gains:
//    - ag_tcu_seq_state_e {IDLE, ISSUE, DRAIN}
//    - typedef ag_tcu_uop_t {uuid, wid, pc, rd, fmt_s, fmt_d, step_m, step_n, sop, eop}
//  - Sub-module VX_ag_tcu_credit_cnt (up/down saturating counter with full/empty flags); reused by other issue paths.
//  - Remaining logic (FSM, step counters, rd adder) stays inline.
// TESTING
//  1. m_cnt=1, n_cnt=2, rd=8, out_ready=1, rsp_fire echoes issue delayed 5 cycles
//     -> 6 uops (m,n)=(0,0),(0,1),(0,2),(1,0),(1,1),(1,2); rd=8..13; sop on 1st, eop on 6th; done 1 pulse; in_ready=1 after.
//  2. MAX_INFL=4, 8 steps, rsp_fire held 0
//     -> exactly 4 uops issue, then out_valid=0. One rsp_fire -> exactly 1 more issues.
//  3. out_ready toggled randomly with 3-cycle stalls
//     -> payload stable while valid && !ready; no uop lost or duplicated; order preserved.
//  4. out fire and rsp_fire in the same cycle at credits=MAX_INFL-1 -> credits stay MAX_INFL-1; next issue allowed.
//  5. m_cnt=n_cnt=0 -> single uop with sop=eop=1; done 1 cycle after its rsp_fire.
//  6. reset asserted mid-ISSUE (async, between edges)
//     -> out_valid=0 and busy=0 immediately; after release, new macro-op starts at (0,0) with credits=0.

Source files
------------

// File: rtl/vx_ag_tcu_step_seq_pkg.sv
// Shared types for the AG-TCU issue-side step sequencer.
package vx_ag_tcu_step_seq_pkg;

  localparam int unsigned AG_TCU_UUID_W = 44;
  localparam int unsigned AG_TCU_NW_W   = 2;
  localparam int unsigned AG_TCU_PC_W   = 30;
  localparam int unsigned AG_TCU_RD_W   = 6;
  localparam int unsigned AG_TCU_STEP_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } ag_tcu_seq_state_e;

  typedef struct packed {
    logic [AG_TCU_UUID_W-1:0] uuid;
    logic [AG_TCU_NW_W-1:0]   wid;
    logic [AG_TCU_PC_W-1:0]   pc;
    logic [AG_TCU_RD_W-1:0]   rd;
    logic [3:0]               fmt_s;
    logic [3:0]               fmt_d;
    logic [AG_TCU_STEP_W-1:0] step_m;
    logic [AG_TCU_STEP_W-1:0] step_n;
    logic                     sop;
    logic                     eop;
  } ag_tcu_uop_t;

endpackage

// File: rtl/vx_ag_tcu_step_seq_credit_cnt.sv
// Up/down in-flight credit counter with full/empty flags; holds at both ends.
module vx_ag_tcu_step_seq_credit_cnt #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = $clog2(MAX) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == W'(MAX));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !full) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec && !inc && !empty) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A retire with nothing outstanding is an upstream protocol error.
  assert property (@(posedge clk) disable iff (reset) !(dec && empty));

endmodule

// File: rtl/vx_ag_tcu_step_seq.sv
// Expands one AG-TCU tile macro-op into M x N per-step micro-ops, credit-limited,
// and pulses done once every issued step has retired.
module vx_ag_tcu_step_seq
  import vx_ag_tcu_step_seq_pkg::*;
#(
  parameter int unsigned UUID_W   = 44,
  parameter int unsigned NW_W     = 2,
  parameter int unsigned PC_W     = 30,
  parameter int unsigned RD_W     = 6,
  parameter int unsigned STEP_W   = 4,
  parameter int unsigned MAX_INFL = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [UUID_W-1:0] in_uuid,
  input  logic [NW_W-1:0]   in_wid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [3:0]        in_fmt_s,
  input  logic [3:0]        in_fmt_d,
  input  logic [STEP_W-1:0] in_m_cnt,
  input  logic [STEP_W-1:0] in_n_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UUID_W-1:0] out_uuid,
  output logic [NW_W-1:0]   out_wid,
  output logic [PC_W-1:0]   out_pc,
  output logic [3:0]        out_fmt_s,
  output logic [3:0]        out_fmt_d,
  output logic [RD_W-1:0]   out_rd,
  output logic [STEP_W-1:0] out_step_m,
  output logic [STEP_W-1:0] out_step_n,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              rsp_fire,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(MAX_INFL) + 1;

  typedef struct packed {
    logic [UUID_W-1:0] uuid;
    logic [NW_W-1:0]   wid;
    logic [PC_W-1:0]   pc;
    logic [3:0]        fmt_s;
    logic [3:0]        fmt_d;
    logic [STEP_W-1:0] m_cnt;
    logic [STEP_W-1:0] n_cnt;
  } hdr_t;

  ag_tcu_seq_state_e state_q, state_d;
  hdr_t              hdr_q;
  logic [STEP_W-1:0] m_q, n_q;
  logic [RD_W-1:0]   rd_q;
  logic              done_q;
  logic [CNT_W-1:0]  credits;
  logic              cred_full, cred_empty;
  logic              in_fire, out_fire, last_step, drain_exit;

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = (state_q == ISSUE) && !cred_full;
  assign out_fire   = out_valid && out_ready;
  assign last_step  = (m_q == hdr_q.m_cnt) && (n_q == hdr_q.n_cnt);
  // No issue happens in DRAIN, so only a retire can move the count toward zero.
  assign drain_exit = cred_empty || ((credits == CNT_W'(1)) && rsp_fire);

  assign out_uuid   = hdr_q.uuid;
  assign out_wid    = hdr_q.wid;
  assign out_pc     = hdr_q.pc;
  assign out_fmt_s  = hdr_q.fmt_s;
  assign out_fmt_d  = hdr_q.fmt_d;
  assign out_rd     = rd_q;
  assign out_step_m = m_q;
  assign out_step_n = n_q;
  assign out_sop    = (state_q == ISSUE) && (m_q == '0) && (n_q == '0);
  assign out_eop    = (state_q == ISSUE) && last_step;
  assign done       = done_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_fire) state_d = ISSUE;
      ISSUE:   if (out_fire && last_step) state_d = DRAIN;
      DRAIN:   if (drain_exit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Steps issue n-fastest, so base + m*(n_cnt+1) + n is just base + issue index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DRAIN) && drain_exit;
      if (in_fire) begin
        hdr_q <= '{uuid: in_uuid, wid: in_wid, pc: in_pc, fmt_s: in_fmt_s,
                   fmt_d: in_fmt_d, m_cnt: in_m_cnt, n_cnt: in_n_cnt};
        m_q   <= '0;
        n_q   <= '0;
        rd_q  <= in_rd;
      end else if (out_fire) begin
        rd_q <= rd_q + RD_W'(1);
        if (n_q == hdr_q.n_cnt) begin
          n_q <= '0;
          m_q <= m_q + STEP_W'(1);
        end else begin
          n_q <= n_q + STEP_W'(1);
        end
      end
    end
  end

  vx_ag_tcu_step_seq_credit_cnt #(
    .MAX (MAX_INFL),
    .W   (CNT_W)
  ) u_credit_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_fire),
    .dec   (rsp_fire),
    .count (credits),
    .full  (cred_full),
    .empty (cred_empty)
  );

endmodule

// File: tb/tb_vx_ag_tcu_step_seq.sv
// Bench for vx_ag_tcu_step_seq: queue-based reference of the step expansion and credit window.
module tb_vx_ag_tcu_step_seq;

  localparam int MAXI = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [43:0] in_uuid;
  logic [1:0]  in_wid;
  logic [29:0] in_pc;
  logic [5:0]  in_rd;
  logic [3:0]  in_fmt_s, in_fmt_d, in_m_cnt, in_n_cnt;
  logic        out_valid, out_ready;
  logic [43:0] out_uuid;
  logic [1:0]  out_wid;
  logic [29:0] out_pc;
  logic [3:0]  out_fmt_s, out_fmt_d;
  logic [5:0]  out_rd;
  logic [3:0]  out_step_m, out_step_n;
  logic        out_sop, out_eop, rsp_fire, busy, done;

  always #5 clk = ~clk;

  vx_ag_tcu_step_seq #(.MAX_INFL(MAXI)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_pc(in_pc), .in_rd(in_rd), .in_fmt_s(in_fmt_s), .in_fmt_d(in_fmt_d),
    .in_m_cnt(in_m_cnt), .in_n_cnt(in_n_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid), .out_wid(out_wid),
    .out_pc(out_pc), .out_fmt_s(out_fmt_s), .out_fmt_d(out_fmt_d), .out_rd(out_rd),
    .out_step_m(out_step_m), .out_step_n(out_step_n), .out_sop(out_sop), .out_eop(out_eop),
    .rsp_fire(rsp_fire), .busy(busy), .done(done)
  );

  typedef struct {
    logic [5:0] rd;
    logic [3:0] m, n;
    logic       sop, eop;
  } uop_t;

  typedef struct {
    logic [5:0] rd;
    logic [3:0] mc, nc;
    int         rdy_mode;
    int         rsp_mode;
    int         exp_uops;
    logic [5:0] exp_last_rd;
  } vec_t;

  uop_t        exp_q[$];
  int          due_q[$];
  int          total = 0, bad = 0;
  int          cyc = 0, outst = 0, fires = 0, stall_left = 0;
  int          ready_mode = 0, rsp_mode = 0;
  bit          idle = 1'b1, exp_done = 1'b0;
  logic [5:0]  last_rd;
  logic [43:0] e_uuid;
  logic [39:0] e_misc;
  vec_t        vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load_model();
    uop_t u;
    e_uuid = in_uuid;
    e_misc = {in_wid, in_pc, in_fmt_s, in_fmt_d};
    for (int mm = 0; mm <= int'(in_m_cnt); mm++) begin
      for (int nn = 0; nn <= int'(in_n_cnt); nn++) begin
        u.rd  = 6'(int'(in_rd) + mm * (int'(in_n_cnt) + 1) + nn);
        u.m   = 4'(mm);
        u.n   = 4'(nn);
        u.sop = (mm == 0) && (nn == 0);
        u.eop = (mm == int'(in_m_cnt)) && (nn == int'(in_n_cnt));
        exp_q.push_back(u);
      end
    end
    idle = 1'b0;
  endtask

  // One clock: check outputs at the negedge, pick fires, advance model across the posedge.
  task automatic tick();
    bit   ev, of, inf, drain;
    int   n_out;
    uop_t u;
    if (ready_mode == 1) begin
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else if ($urandom_range(0, 3) == 0) begin
        out_ready  = 1'b0;
        stall_left = 2;
      end else begin
        out_ready = 1'b1;
      end
    end else if (ready_mode == 2) begin
      out_ready = 1'($urandom_range(0, 1));
    end
    if (rsp_mode == 1)      rsp_fire = (due_q.size() > 0) && (due_q[0] <= cyc);
    else if (rsp_mode == 2) rsp_fire = (outst > 0) && ($urandom_range(0, 2) == 0);

    ev = !idle && (exp_q.size() > 0) && (outst < MAXI);
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("in_ready", 64'(in_ready), 64'(idle));
    chk("busy", 64'(busy), 64'(!idle));
    chk("done", 64'(done), 64'(exp_done));
    if (ev) begin
      u = exp_q[0];
      chk("rd", 64'(out_rd), 64'(u.rd));
      chk("step_mn", 64'({out_step_m, out_step_n}), 64'({u.m, u.n}));
      chk("sop_eop", 64'({out_sop, out_eop}), 64'({u.sop, u.eop}));
      chk("uuid", 64'(out_uuid), 64'(e_uuid));
      chk("wid_pc_fmt", 64'({out_wid, out_pc, out_fmt_s, out_fmt_d}), 64'(e_misc));
    end
    if (out_valid && out_ready) begin
      fires++;
      last_rd = out_rd;
    end

    of    = ev && out_ready;
    inf   = idle && in_valid;
    drain = !idle && (exp_q.size() == 0);
    n_out = outst + int'(of) - int'(rsp_fire);
    if (of) begin
      void'(exp_q.pop_front());
      if (rsp_mode == 1) due_q.push_back(cyc + 5);
    end
    if (rsp_fire && rsp_mode == 1) void'(due_q.pop_front());
    exp_done = drain && (n_out == 0);
    if (exp_done) idle = 1'b1;
    if (inf) load_model();
    outst = n_out;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (inf) in_valid = 1'b0;
  endtask

  task automatic start(input logic [5:0] rd, input logic [3:0] mc, input logic [3:0] nc);
    in_uuid  = 44'({$urandom(), $urandom()});
    in_wid   = 2'($urandom());
    in_pc    = 30'($urandom());
    in_fmt_s = 4'($urandom());
    in_fmt_d = 4'($urandom());
    in_rd    = rd;
    in_m_cnt = mc;
    in_n_cnt = nc;
    in_valid = 1'b1;
    fires    = 0;
  endtask

  task automatic finish_macro();
    int guard = 0;
    while (!idle && guard < 5000) begin
      tick();
      guard++;
    end
    chk("drain_timeout", 64'(guard < 5000), 64'(1));
    tick();
  endtask

  task automatic run_checked(input logic [5:0] rd, input logic [3:0] mc, input logic [3:0] nc,
                             input int exp_uops, input logic [5:0] exp_last);
    start(rd, mc, nc);
    tick();
    finish_macro();
    chk("uop_count", 64'(fires), 64'(exp_uops));
    chk("last_rd", 64'(last_rd), 64'(exp_last));
  endtask

  initial begin
    vecs[0] = '{rd: 6'd8,  mc: 4'd1,  nc: 4'd2,  rdy_mode: 0, rsp_mode: 1, exp_uops: 6,   exp_last_rd: 6'd13};
    vecs[1] = '{rd: 6'd60, mc: 4'd0,  nc: 4'd7,  rdy_mode: 1, rsp_mode: 2, exp_uops: 8,   exp_last_rd: 6'd3};
    vecs[2] = '{rd: 6'd0,  mc: 4'd15, nc: 4'd15, rdy_mode: 2, rsp_mode: 2, exp_uops: 256, exp_last_rd: 6'd63};
    vecs[3] = '{rd: 6'd5,  mc: 4'd0,  nc: 4'd0,  rdy_mode: 0, rsp_mode: 1, exp_uops: 1,   exp_last_rd: 6'd5};
    vecs[4] = '{rd: 6'd33, mc: 4'd3,  nc: 4'd0,  rdy_mode: 1, rsp_mode: 1, exp_uops: 4,   exp_last_rd: 6'd36};
    vecs[5] = '{rd: 6'd63, mc: 4'd2,  nc: 4'd1,  rdy_mode: 2, rsp_mode: 2, exp_uops: 6,   exp_last_rd: 6'd4};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rsp_fire = 1'b0;
    in_uuid = '0; in_wid = '0; in_pc = '0; in_rd = '0;
    in_fmt_s = '0; in_fmt_d = '0; in_m_cnt = '0; in_n_cnt = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_busy_done", 64'({busy, done}), 64'(0));
    chk("rst_payload", 64'({out_uuid[19:0], out_rd, out_step_m, out_step_n, out_sop, out_eop}), 64'(0));
    reset = 1'b0;

    foreach (vecs[i]) begin
      ready_mode = vecs[i].rdy_mode;
      rsp_mode   = vecs[i].rsp_mode;
      out_ready  = 1'b1;
      stall_left = 0;
      due_q.delete();
      run_checked(vecs[i].rd, vecs[i].mc, vecs[i].nc, vecs[i].exp_uops, vecs[i].exp_last_rd);
    end

    // Credit window of MAX_INFL with no retires, then exactly one more after one retire.
    ready_mode = 0; out_ready = 1'b1; rsp_mode = 0; rsp_fire = 1'b0;
    start(6'd20, 4'd1, 4'd3);
    tick();
    repeat (8) tick();
    chk("credit_block", 64'(fires), 64'(MAXI));
    rsp_fire = 1'b1;
    tick();
    rsp_fire = 1'b0;
    repeat (5) tick();
    chk("credit_one_more", 64'(fires), 64'(MAXI + 1));
    rsp_mode = 2;
    finish_macro();

    // Simultaneous issue and retire at MAX_INFL-1 leaves room for one more issue.
    rsp_mode = 0; rsp_fire = 1'b0; out_ready = 1'b1;
    start(6'd40, 4'd1, 4'd3);
    tick();
    for (int g = 0; g < 20 && fires < MAXI - 1; g++) tick();
    chk("near_full_fires", 64'(fires), 64'(MAXI - 1));
    rsp_fire = 1'b1;
    tick();
    rsp_fire = 1'b0;
    chk("same_cycle_valid", 64'(out_valid), 64'(1));
    chk("same_cycle_fires", 64'(fires), 64'(MAXI));
    tick();
    chk("full_after_issue", 64'(out_valid), 64'(0));
    rsp_mode = 2;
    finish_macro();

    for (int r = 0; r < 8; r++) begin
      int unsigned mc, nc, rd;
      mc = $urandom_range(0, 4);
      nc = $urandom_range(0, 4);
      rd = $urandom_range(0, 63);
      ready_mode = int'($urandom_range(1, 2));
      rsp_mode   = 2;
      run_checked(6'(rd), 4'(mc), 4'(nc), int'((mc + 1) * (nc + 1)), 6'(rd + mc * (nc + 1) + nc));
    end

    // Asynchronous reset between edges abandons the macro-op.
    ready_mode = 1; rsp_mode = 2; stall_left = 0;
    start(6'd12, 4'd3, 4'd3);
    tick();
    repeat (6) tick();
    chk("pre_reset_busy", 64'(busy), 64'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_in_ready", 64'(in_ready), 64'(1));
    rsp_fire = 1'b0; in_valid = 1'b0;
    exp_q.delete(); due_q.delete();
    outst = 0; idle = 1'b1; exp_done = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ready_mode = 0; out_ready = 1'b1; rsp_mode = 1;
    start(6'd50, 4'd1, 4'd1);
    tick();
    chk("post_rst_first", 64'({out_valid, out_step_m, out_step_n, out_sop}), 64'({1'b1, 8'd0, 1'b1}));
    finish_macro();
    chk("post_rst_count", 64'(fires), 64'(4));
    chk("post_rst_last_rd", 64'(last_rd), 64'(53));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
